data_mem_responder: RTL and testbench

//  Target side of the MEM-stage load/store interface: accepts one request at a time from the pipeline's MEM stage,

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/data_mem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication plus byte enables, and load
// lane extraction with RISC-V sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wdata_rep_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and half-word from the read word.
    always_comb begin
        byte_s = 8'd0;
        half_s = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (addr_lo_i)
            2'd0:    byte_s = rword_i[7:0];
            2'd1:    byte_s = rword_i[15:8];
            2'd2:    byte_s = rword_i[23:16];
            2'd3:    byte_s = rword_i[31:24];
            default: byte_s = 8'd0;
        endcase
    end

    // Per-size store replication, byte enables and load extension.
    always_comb begin
        wdata_rep_o = wdata_i;
        be_o        = 4'b0000;
        rdata_o     = 32'd0;
        case (size_i)
            SZ_BYTE: begin
                wdata_rep_o = {4{wdata_i[7:0]}};
                be_o        = 4'b0001 << addr_lo_i;
                rdata_o     = {{24{~unsigned_i & byte_s[7]}}, byte_s};
            end
            SZ_HALF: begin
                wdata_rep_o = {2{wdata_i[15:0]}};
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                rdata_o     = {{16{~unsigned_i & half_s[15]}}, half_s};
            end
            SZ_WORD: begin
                wdata_rep_o = wdata_i;
                be_o        = 4'b1111;
                rdata_o     = rword_i;
            end
            default: begin
                wdata_rep_o = wdata_i;
                be_o        = 4'b0000;
                rdata_o     = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory target with configurable wait states, byte-lane
// stores, extended loads and valid/ready response back-pressure.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic            wr_q;
    mem_size_e       size_q;
    logic            uns_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]     wdata_q;

    logic            accept_s, err_s, commit_s;
    logic            c_write_s, c_uns_s;
    mem_size_e       c_size_s;
    logic [IDX_W+1:0] c_addr_s;
    logic [31:0]     c_wdata_s, rword_s, wrep_s, load_ext_s;
    logic [3:0]      be_s;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign accept_s = req_valid && req_ready_q;
    assign err_s    = (mem_size_e'(req_size) == SZ_BAD)
                   || is_misaligned(mem_size_e'(req_size), req_addr[1:0])
                   || (req_addr >= ADDR_LIMIT);

    // With zero wait states the access commits on the accept edge, so use live inputs then.
    always_comb begin
        if (state_q == IDLE) begin
            c_write_s = req_write;
            c_size_s  = mem_size_e'(req_size);
            c_uns_s   = req_unsigned;
            c_addr_s  = req_addr[IDX_W+1:0];
            c_wdata_s = req_wdata;
        end else begin
            c_write_s = wr_q;
            c_size_s  = size_q;
            c_uns_s   = uns_q;
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
        end
    end

    assign rword_s = mem_q[c_addr_s[IDX_W+1:2]];

    mem_lane_align u_align (
        .size_i      (c_size_s),
        .addr_lo_i   (c_addr_s[1:0]),
        .unsigned_i  (c_uns_s),
        .wdata_i     (c_wdata_s),
        .rword_i     (rword_s),
        .wdata_rep_o (wrep_s),
        .be_o        (be_s),
        .rdata_o     (load_ext_s)
    );

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        commit_s    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        commit_s    = 1'b1;
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = c_write_s ? 32'd0 : load_ext_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit_s    = 1'b1;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = c_write_s ? 32'd0 : load_ext_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Control state and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (accept_s) begin
            wr_q    <= req_write;
            size_q  <= mem_size_e'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[IDX_W+1:0];
            wdata_q <= req_wdata;
        end else begin
            wr_q    <= wr_q;
            size_q  <= size_q;
            uns_q   <= uns_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
        end
    end

    // Byte-enable write; gated by rst_n so an abandoned store never lands.
    always_ff @(posedge clk) begin
        if (rst_n && commit_s && c_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[c_addr_s[IDX_W+1:2]][8*i +: 8] <= wrep_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (DEPTH_WORDS=1024, WAIT_STATES=2).
module tb_data_mem_responder;

    localparam int WS = 2;
    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs === exp_v) pass_cnt++;
        else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    endtask

    // Drive one request, push its expectation, return #1 after the accept edge.
    task automatic send(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        e.err   = exp_err;
        e.rdata = exp_err ? 32'd0 : exp_rd;
        e.lat   = exp_err ? 1 : WS + 1;
        sb_q.push_back(e);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) check_eq({tag, "_accept_timeout"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, compare against the scoreboard, optionally stall, then handshake.
    task automatic collect(input string tag, input int stall);
        exp_t e;
        int   lat;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, {31'd0, rsp_valid}, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
            check_eq({tag, "_lat"},   32'(lat), 32'(e.lat));
            check_eq({tag, "_err"},   {31'd0, rsp_err}, {31'd0, e.err});
            check_eq({tag, "_rdata"}, rsp_rdata, e.rdata);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check_eq({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
                check_eq({tag, "_hold_err"},   {31'd0, rsp_err}, {31'd0, e.err});
                check_eq({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
                check_eq({tag, "_hold_rdy"},   {31'd0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
        send(tag, w, sz, uns, a, wd, exp_err, exp_rd);
        collect(tag, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h0000_0010; req_wdata = 32'd0; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
            check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Word store/load
        xfer("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
        xfer("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);

        // Sub-word lanes
        xfer("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h0000_0000, 1'b0, 32'd0);
        xfer("sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFF_FF80, 1'b0, 32'd0);
        xfer("lb21", 1'b0, 2'd0, 1'b0, 32'h21, 32'd0, 1'b0, 32'hFFFF_FF80);
        xfer("lbu21", 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 1'b0, 32'h0000_0080);
        xfer("lw20a", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 32'h0000_8000);
        xfer("sh22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD_1234, 1'b0, 32'd0);
        xfer("lw20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 32'h1234_8000);
        xfer("lh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 1'b0, 32'h0000_1234);
        xfer("lhu20", 1'b0, 2'd1, 1'b1, 32'h20, 32'd0, 1'b0, 32'h0000_8000);
        xfer("lh20", 1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hFFFF_8000);

        // Errors leave the target words untouched
        xfer("sw00", 1'b1, 2'd2, 1'b0, 32'h00, 32'h55AA_55AA, 1'b0, 32'd0);
        xfer("sw04", 1'b1, 2'd2, 1'b0, 32'h04, 32'h0102_0304, 1'b0, 32'd0);
        xfer("sw08", 1'b1, 2'd2, 1'b0, 32'h08, 32'h0A0B_0C0D, 1'b0, 32'd0);
        xfer("err_lh03", 1'b0, 2'd1, 1'b0, 32'h03, 32'd0, 1'b1, 32'd0);
        xfer("err_sw06", 1'b1, 2'd2, 1'b0, 32'h06, 32'hFFFF_FFFF, 1'b1, 32'd0);
        xfer("err_sz3", 1'b1, 2'd3, 1'b0, 32'h08, 32'hFFFF_FFFF, 1'b1, 32'd0);
        xfer("err_oor", 1'b0, 2'd2, 1'b0, 32'(4 * DW), 32'd0, 1'b1, 32'd0);
        xfer("err_oor_sb", 1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_00EE, 1'b1, 32'd0);
        xfer("lw00", 1'b0, 2'd2, 1'b0, 32'h00, 32'd0, 1'b0, 32'h55AA_55AA);
        xfer("lw04", 1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 1'b0, 32'h0102_0304);
        xfer("lw08", 1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 1'b0, 32'h0A0B_0C0D);
        xfer("sw_last", 1'b1, 2'd2, 1'b0, 32'(4 * DW - 4), 32'h7777_0001, 1'b0, 32'd0);
        xfer("lw_last", 1'b0, 2'd2, 1'b0, 32'(4 * DW - 4), 32'd0, 1'b0, 32'h7777_0001);

        // Back-pressure with a second request held on the bus
        send("bp1", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'd0;
        collect("bp1", 5);
        check_eq("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
        send("bp2", 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0, 32'h1234_8000);
        collect("bp2", 0);

        // Reset in WAIT abandons the store
        xfer("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'h1111_1111, 1'b0, 32'd0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rel_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("mid_no_stale", {31'd0, rsp_valid}, 32'd0);
        end
        xfer("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0, 32'h1111_1111);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
